// File: rtl/mmss_timer.sv
// ---------------------------------------------------------------------------
// mmss_timer
//
// Purpose:
//   Minutes:seconds timer with BCD digit outputs. A prescaler divides clk
//   down to one tick per second. Each tick moves the displayed value one
//   second up or down. A small command port supports three operations:
//   clearing the seconds, adding a minute, and clearing everything.
//
// Parameters:
//   CLK_HZ   clk cycles per counted second (>= 2)
//   MIN_MAX  highest displayed minute value (1..99); minutes wrap to 00 above it
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   op[1:0]    command: 00 none, 01 seconds-to-zero, 10 minute-add, 11 clear-all
//   run        1 = count, 0 = freeze (prescaler and digits hold)
//   down       0 = count up, 1 = count down (00:00 is the floor)
//   op_ack     registered high in the cycle after any nonzero op
//   dis_mX     BCD minute tens
//   dis_mU     BCD minute units
//   dis_sX     BCD second tens (0..5)
//   dis_sU     BCD second units
//   sec_tick   one-cycle pulse, coincident with the digits updated by a tick
//   expired    one-cycle pulse when a countdown lands on 00:00
// ---------------------------------------------------------------------------
module mmss_timer #(
    parameter int CLK_HZ  = 50000000,
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] op,
    input  logic       run,
    input  logic       down,
    output logic       op_ack,
    output logic [3:0] dis_mX,
    output logic [3:0] dis_mU,
    output logic [3:0] dis_sX,
    output logic [3:0] dis_sU,
    output logic       sec_tick,
    output logic       expired
);

    localparam int             PW         = $clog2(CLK_HZ);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);

    localparam logic [3:0]     MAX_X      = 4'(MIN_MAX / 10);
    localparam logic [3:0]     MAX_U      = 4'(MIN_MAX % 10);

    localparam logic [1:0]     OP_NONE     = 2'b00;
    localparam logic [1:0]     OP_SEC_ZERO = 2'b01;
    localparam logic [1:0]     OP_MIN_ADD  = 2'b10;
    localparam logic [1:0]     OP_CLEAR    = 2'b11;

    logic [PW-1:0] r_presc;
    logic [3:0]    r_mX;
    logic [3:0]    r_mU;
    logic [3:0]    r_sX;
    logic [3:0]    r_sU;
    logic          r_opAck;
    logic          r_secTick;
    logic          r_expired;

    logic          w_prescAtLast;
    logic [PW-1:0] w_prescNext;
    logic          w_tick;
    logic          w_isZero;
    logic          w_isOne;
    logic          w_minAtMax;

    logic [3:0]    w_minIncX;
    logic [3:0]    w_minIncU;

    logic [3:0]    w_upMX;
    logic [3:0]    w_upMU;
    logic [3:0]    w_upSX;
    logic [3:0]    w_upSU;

    logic [3:0]    w_dnMX;
    logic [3:0]    w_dnMU;
    logic [3:0]    w_dnSX;
    logic [3:0]    w_dnSU;

    // The tick is the cycle on which a running prescaler wraps back to zero.
    // A frozen prescaler sitting on its last value does not tick until run
    // returns, so the second resumes exactly where it was paused.
    assign w_prescAtLast = (r_presc == PRESC_LAST);
    assign w_prescNext   = w_prescAtLast ? '0 : r_presc + 1'b1;
    assign w_tick        = run & w_prescAtLast;

    // 00:00 is the countdown floor. 00:01 is the only value from which a
    // down tick lands on the floor, so that value identifies an expiry.
    assign w_isZero   = (r_mX == 4'd0) && (r_mU == 4'd0) &&
                        (r_sX == 4'd0) && (r_sU == 4'd0);
    assign w_isOne    = (r_mX == 4'd0) && (r_mU == 4'd0) &&
                        (r_sX == 4'd0) && (r_sU == 4'd1);
    assign w_minAtMax = (r_mX == MAX_X) && (r_mU == MAX_U);

    // BCD minute increment, shared by the minute-add command and by the
    // carry out of the seconds when counting up. Wraps MIN_MAX -> 00.
    always_comb begin
        w_minIncX = r_mX;
        w_minIncU = r_mU;
        if (w_minAtMax) begin
            w_minIncX = 4'd0;
            w_minIncU = 4'd0;
        end else if (r_mU == 4'd9) begin
            w_minIncX = r_mX + 4'd1;
            w_minIncU = 4'd0;
        end else begin
            w_minIncU = r_mU + 4'd1;
        end
    end

    // Next value for an up tick: units, then tens (0..5), then minutes.
    always_comb begin
        w_upMX = r_mX;
        w_upMU = r_mU;
        w_upSX = r_sX;
        w_upSU = r_sU;
        if (r_sU != 4'd9) begin
            w_upSU = r_sU + 4'd1;
        end else begin
            w_upSU = 4'd0;
            if (r_sX != 4'd5) begin
                w_upSX = r_sX + 4'd1;
            end else begin
                w_upSX = 4'd0;
                w_upMX = w_minIncX;
                w_upMU = w_minIncU;
            end
        end
    end

    // Next value for a down tick. At 00:00 the value holds; elsewhere the
    // borrow chain never reaches past the minute tens because the floor
    // stops it first.
    always_comb begin
        w_dnMX = r_mX;
        w_dnMU = r_mU;
        w_dnSX = r_sX;
        w_dnSU = r_sU;
        if (!w_isZero) begin
            if (r_sU != 4'd0) begin
                w_dnSU = r_sU - 4'd1;
            end else begin
                w_dnSU = 4'd9;
                if (r_sX != 4'd0) begin
                    w_dnSX = r_sX - 4'd1;
                end else begin
                    w_dnSX = 4'd5;
                    if (r_mU != 4'd0) begin
                        w_dnMU = r_mU - 4'd1;
                    end else begin
                        w_dnMU = 4'd9;
                        w_dnMX = r_mX - 4'd1;
                    end
                end
            end
        end
    end

    // Main state register. Reset wins over everything. A nonzero command is
    // applied on every cycle it is present and swallows a coincident tick:
    // the digits take the command's result only, and neither sec_tick nor
    // expired fires. The prescaler still wraps on such a tick unless the
    // command itself clears it, so the next second is a full one either way.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_mX      <= 4'd0;
            r_mU      <= 4'd0;
            r_sX      <= 4'd0;
            r_sU      <= 4'd0;
            r_opAck   <= 1'b0;
            r_secTick <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_opAck   <= (op != OP_NONE);
            r_secTick <= 1'b0;
            r_expired <= 1'b0;

            case (op)
                OP_SEC_ZERO: begin
                    r_sX    <= 4'd0;
                    r_sU    <= 4'd0;
                    r_presc <= '0;
                end

                OP_CLEAR: begin
                    r_mX    <= 4'd0;
                    r_mU    <= 4'd0;
                    r_sX    <= 4'd0;
                    r_sU    <= 4'd0;
                    r_presc <= '0;
                end

                OP_MIN_ADD: begin
                    r_mX <= w_minIncX;
                    r_mU <= w_minIncU;
                    if (run) begin
                        r_presc <= w_prescNext;
                    end
                end

                default: begin
                    if (run) begin
                        r_presc <= w_prescNext;
                    end
                    if (w_tick) begin
                        r_secTick <= 1'b1;
                        if (down) begin
                            r_mX      <= w_dnMX;
                            r_mU      <= w_dnMU;
                            r_sX      <= w_dnSX;
                            r_sU      <= w_dnSU;
                            r_expired <= w_isOne;
                        end else begin
                            r_mX <= w_upMX;
                            r_mU <= w_upMU;
                            r_sX <= w_upSX;
                            r_sU <= w_upSU;
                        end
                    end
                end
            endcase
        end
    end

    assign op_ack   = r_opAck;
    assign dis_mX   = r_mX;
    assign dis_mU   = r_mU;
    assign dis_sX   = r_sX;
    assign dis_sU   = r_sU;
    assign sec_tick = r_secTick;
    assign expired  = r_expired;

endmodule

// File: tb/tb_mmss_timer.sv
// ---------------------------------------------------------------------------
// tb_mmss_timer
//
// Drives two timers (MIN_MAX = 2 and MIN_MAX = 59, both CLK_HZ = 4) with the
// same inputs. A reference model keeps each timer's value as a plain count of
// seconds plus a prescaler count, and every cycle both timers are compared
// against it. Directed scenarios also compare against literal values.
// ---------------------------------------------------------------------------
module tb_mmss_timer;

   localparam int CLK_HZ = 4;
   localparam int MAX0   = 2;
   localparam int MAX1   = 59;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] op;
   logic       run;
   logic       down;

   logic       ack0, st0, ex0;
   logic [3:0] mX0, mU0, sX0, sU0;
   logic       ack1, st1, ex1;
   logic [3:0] mX1, mU1, sX1, sU1;

   int nCompared = 0;
   int nMismatch = 0;
   int stCount   = 0;
   int exCount   = 0;

   int   mTotal[2];
   int   mPresc[2];
   logic mAck[2];
   logic mSt[2];
   logic mEx[2];

   mmss_timer #(.CLK_HZ(CLK_HZ), .MIN_MAX(MAX0)) dut0 (
      .clk(clk), .rst_n(rst_n), .op(op), .run(run), .down(down),
      .op_ack(ack0), .dis_mX(mX0), .dis_mU(mU0), .dis_sX(sX0), .dis_sU(sU0),
      .sec_tick(st0), .expired(ex0)
   );

   mmss_timer #(.CLK_HZ(CLK_HZ), .MIN_MAX(MAX1)) dut1 (
      .clk(clk), .rst_n(rst_n), .op(op), .run(run), .down(down),
      .op_ack(ack1), .dis_mX(mX1), .dis_mU(mU1), .dis_sX(sX1), .dis_sU(sU1),
      .sec_tick(st1), .expired(ex1)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   function automatic int maxOf(input int idx);
      return (idx == 0) ? MAX0 : MAX1;
   endfunction

   // Converts a seconds count into the four BCD display digits {mX,mU,sX,sU}.
   function automatic logic [15:0] toDigits(input int total);
      int m;
      int s;
      m = total / 60;
      s = total % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   // Advances one timer model by a clock edge using the inputs that were
   // present at that edge. The value is a seconds count so carries, borrows
   // and wraps fall out of ordinary arithmetic.
   task automatic modelStep(input int idx);
      bit tick;
      int mins;
      int span;
      span = (maxOf(idx) + 1) * 60;
      if (!rst_n) begin
         mTotal[idx] = 0;
         mPresc[idx] = 0;
         mAck[idx]   = 1'b0;
         mSt[idx]    = 1'b0;
         mEx[idx]    = 1'b0;
      end else begin
         tick      = run && (mPresc[idx] == CLK_HZ - 1);
         mAck[idx] = (op != 2'b00);
         mSt[idx]  = 1'b0;
         mEx[idx]  = 1'b0;
         if (op == 2'b01) begin
            mTotal[idx] = (mTotal[idx] / 60) * 60;
            mPresc[idx] = 0;
         end else if (op == 2'b11) begin
            mTotal[idx] = 0;
            mPresc[idx] = 0;
         end else begin
            if (op == 2'b10) begin
               mins        = (mTotal[idx] / 60 + 1) % (maxOf(idx) + 1);
               mTotal[idx] = mins * 60 + mTotal[idx] % 60;
            end
            if (run) mPresc[idx] = (mPresc[idx] + 1) % CLK_HZ;
            if (op == 2'b00 && tick) begin
               mSt[idx] = 1'b1;
               if (down) begin
                  if (mTotal[idx] > 0) begin
                     mTotal[idx] = mTotal[idx] - 1;
                     mEx[idx]    = (mTotal[idx] == 0);
                  end
               end else begin
                  mTotal[idx] = (mTotal[idx] + 1) % span;
               end
            end
         end
      end
   endtask

   // One comparison: counts it, and on a difference counts a failure and
   // reports the tag with observed and expected values.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatch++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compares every output of one timer with its model.
   task automatic checkDut(input int idx, input logic [15:0] dig, input logic ack,
                           input logic st, input logic ex);
      string pfx;
      pfx = (idx == 0) ? "dut0" : "dut1";
      checkOutput({pfx, " digits"},   {16'h0, dig}, {16'h0, toDigits(mTotal[idx])});
      checkOutput({pfx, " op_ack"},   {31'h0, ack}, {31'h0, mAck[idx]});
      checkOutput({pfx, " sec_tick"}, {31'h0, st},  {31'h0, mSt[idx]});
      checkOutput({pfx, " expired"},  {31'h0, ex},  {31'h0, mEx[idx]});
   endtask

   // Runs n clock edges with the current inputs, advancing the models at each
   // edge and checking both timers 1 time unit after it.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         modelStep(0);
         modelStep(1);
         #1;
         checkDut(0, {mX0, mU0, sX0, sU0}, ack0, st0, ex0);
         checkDut(1, {mX1, mU1, sX1, sU1}, ack1, st1, ex1);
         if (st0) stCount++;
         if (ex0) exCount++;
      end
   endtask

   // Directed scenarios followed by a randomized run.
   initial begin
      rst_n = 1'b0;
      op    = 2'b00;
      run   = 1'b0;
      down  = 1'b0;

      $display("[TB] reset state");
      applyStimulus(3);
      checkOutput("reset digits", {16'h0, mX0, mU0, sX0, sU0}, 32'h0000);
      checkOutput("reset op_ack", {31'h0, ack0}, 32'h0);

      $display("[TB] up count wrap with MIN_MAX=2");
      rst_n   = 1'b1;
      run     = 1'b1;
      down    = 1'b0;
      stCount = 0;
      exCount = 0;
      applyStimulus(179 * 4);
      checkOutput("wrap tick179 dut0", {16'h0, mX0, mU0, sX0, sU0}, 32'h0259);
      applyStimulus(4);
      checkOutput("wrap tick180 dut0", {16'h0, mX0, mU0, sX0, sU0}, 32'h0000);
      checkOutput("wrap tick180 dut1", {16'h0, mX1, mU1, sX1, sU1}, 32'h0300);
      checkOutput("wrap sec_tick count", stCount, 180);
      checkOutput("wrap expired count", exCount, 0);

      $display("[TB] countdown from 01:00");
      run = 1'b0;
      op  = 2'b11;
      applyStimulus(1);
      op = 2'b10;
      applyStimulus(1);
      op      = 2'b00;
      down    = 1'b1;
      run     = 1'b1;
      exCount = 0;
      applyStimulus(4);
      checkOutput("down first tick", {16'h0, mX0, mU0, sX0, sU0}, 32'h0059);
      applyStimulus(59 * 4);
      checkOutput("down reach zero", {16'h0, mX0, mU0, sX0, sU0}, 32'h0000);
      checkOutput("down expired once", exCount, 1);
      exCount = 0;
      applyStimulus(8 * 4);
      checkOutput("down hold zero", {16'h0, mX0, mU0, sX0, sU0}, 32'h0000);
      checkOutput("down hold no expired", exCount, 0);

      $display("[TB] minute add across 59");
      run  = 1'b0;
      down = 1'b0;
      op   = 2'b11;
      applyStimulus(1);
      op = 2'b10;
      applyStimulus(59);
      op = 2'b00;
      applyStimulus(1);
      checkOutput("minadd at 59:00", {16'h0, mX1, mU1, sX1, sU1}, 32'h5900);
      checkOutput("minadd ack idle", {31'h0, ack1}, 32'h0);
      op = 2'b10;
      applyStimulus(1);
      checkOutput("minadd 1 digits", {16'h0, mX1, mU1, sX1, sU1}, 32'h0000);
      checkOutput("minadd 1 ack", {31'h0, ack1}, 32'h1);
      applyStimulus(1);
      checkOutput("minadd 2 digits", {16'h0, mX1, mU1, sX1, sU1}, 32'h0100);
      checkOutput("minadd 2 ack", {31'h0, ack1}, 32'h1);
      applyStimulus(1);
      checkOutput("minadd 3 digits", {16'h0, mX1, mU1, sX1, sU1}, 32'h0200);
      checkOutput("minadd 3 ack", {31'h0, ack1}, 32'h1);
      op = 2'b00;
      applyStimulus(1);
      checkOutput("minadd ack drop", {31'h0, ack1}, 32'h0);

      $display("[TB] seconds-zero on a tick");
      op  = 2'b11;
      run = 1'b0;
      applyStimulus(1);
      op  = 2'b00;
      run = 1'b1;
      applyStimulus(59 * 4 + 3);
      checkOutput("secz before", {16'h0, mX0, mU0, sX0, sU0}, 32'h0059);
      op = 2'b01;
      applyStimulus(1);
      checkOutput("secz digits", {16'h0, mX0, mU0, sX0, sU0}, 32'h0000);
      checkOutput("secz no sec_tick", {31'h0, st0}, 32'h0);
      op      = 2'b00;
      stCount = 0;
      applyStimulus(3);
      checkOutput("secz quiet", stCount, 0);
      applyStimulus(1);
      checkOutput("secz next tick", {16'h0, mX0, mU0, sX0, sU0}, 32'h0001);
      checkOutput("secz next sec_tick", {31'h0, st0}, 32'h1);

      $display("[TB] freeze");
      op  = 2'b11;
      run = 1'b0;
      applyStimulus(1);
      op  = 2'b00;
      run = 1'b1;
      applyStimulus(7 * 4 + 1);
      run     = 1'b0;
      stCount = 0;
      applyStimulus(10);
      checkOutput("freeze digits", {16'h0, mX0, mU0, sX0, sU0}, 32'h0007);
      checkOutput("freeze no tick", stCount, 0);
      run = 1'b1;
      applyStimulus(2);
      checkOutput("resume early", {16'h0, mX0, mU0, sX0, sU0}, 32'h0007);
      applyStimulus(1);
      checkOutput("resume tick", {16'h0, mX0, mU0, sX0, sU0}, 32'h0008);

      $display("[TB] reset mid-count");
      op  = 2'b11;
      run = 1'b0;
      applyStimulus(1);
      op = 2'b10;
      applyStimulus(1);
      op  = 2'b00;
      run = 1'b1;
      applyStimulus(23 * 4 + 2);
      checkOutput("pre-reset digits", {16'h0, mX0, mU0, sX0, sU0}, 32'h0123);
      rst_n = 1'b0;
      applyStimulus(2);
      checkOutput("in-reset digits", {16'h0, mX0, mU0, sX0, sU0}, 32'h0000);
      checkOutput("in-reset flags", {29'h0, ack0, st0, ex0}, 32'h0);
      rst_n = 1'b1;
      applyStimulus(3);
      checkOutput("post-reset early", {16'h0, mX0, mU0, sX0, sU0}, 32'h0000);
      applyStimulus(1);
      checkOutput("post-reset tick", {16'h0, mX0, mU0, sX0, sU0}, 32'h0001);

      $display("[TB] randomized run");
      repeat (1500) begin
         op    = ($urandom_range(0, 99) < 6) ? 2'($urandom_range(1, 3)) : 2'b00;
         run   = ($urandom_range(0, 9) != 0);
         rst_n = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 19) == 0) down = ~down;
         applyStimulus(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/mmss_timer.md
MMSS_TIMER -- requirements
Module: mmss_timer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, SHALL set clk cycles per counted second (legal range >= 2).
REQ-002 Parameter MIN_MAX, default 59, SHALL set the highest displayed minute value (legal range 1..99).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 op  input  2  SHALL select the command: 00 none, 01 seconds-to-zero, 10 minute-add, 11 clear-all.
REQ-006 run  input  1  SHALL enable counting (1 = count, 0 = freeze).
REQ-007 down  input  1  SHALL select direction (0 = count up, 1 = count down).
REQ-008 op_ack  output  1  SHALL acknowledge a command, used to reset the upstream encoder.
REQ-009 dis_mX, dis_mU, dis_sX, dis_sU  output  4 each  SHALL be BCD minute tens, minute units, second tens, second units.
REQ-010 sec_tick  output  1  SHALL pulse for one cycle per counted second.
REQ-011 expired  output  1  SHALL pulse for one cycle when a countdown reaches 00:00.

Function
REQ-012 The prescaler SHALL be $clog2(CLK_HZ) bits wide, SHALL increment when run=1, hold when run=0, and wrap from CLK_HZ-1 to 0.
REQ-013 A tick SHALL occur on the cycle the prescaler wraps; sec_tick SHALL be registered high in the following cycle, coincident with the updated digits.
REQ-014 Up tick: sU SHALL increment; 9 -> 0 with carry into sX; sX 5 -> 0 with carry into minutes; minutes MIN_MAX -> 00.
REQ-015 Down tick, value not 00:00: sU SHALL decrement; 0 -> 9 with borrow from sX; sX 0 -> 5 with borrow from minutes; minutes never underflow because 00:00 is the floor.
REQ-016 Down tick at 00:00: digits SHALL hold; no expired pulse.
REQ-017 expired SHALL pulse only when a down tick changes the value to 00:00, in the same cycle the digits show 00:00.
REQ-018 op 10 SHALL increment minutes in BCD; MIN_MAX -> 00; seconds and prescaler unchanged.
REQ-019 op 01 SHALL zero sX and sU and clear the prescaler to 0.
REQ-020 op 11 SHALL zero all four digits and clear the prescaler to 0.
REQ-021 A nonzero op SHALL be applied on every cycle it is sampled nonzero; there is no edge detection.
REQ-022 op_ack SHALL be registered high in the cycle after any cycle with op != 00, and low otherwise.
REQ-023 When a nonzero op and a tick coincide, the op SHALL apply and the tick SHALL be dropped: no digit change from the tick, no sec_tick, no expired; the prescaler still returns to 0.
REQ-024 Changes to down or run SHALL take effect from the next cycle, with digits unchanged at the change.
REQ-025 Digits SHALL never leave legal BCD: sU/mU 0..9, sX 0..5, minutes 00..MIN_MAX.
REQ-026 The rst_n, op, run and down inputs SHALL be pre-synchronised by the source; the block adds no synchronisers.

Reset
REQ-027 While rst_n=0 at a clk edge, all digits, the prescaler, op_ack, sec_tick and expired SHALL become 0.
REQ-028 Reset SHALL override op and tick in the same cycle; counting SHALL resume from 00:00 with a full CLK_HZ-cycle second after rst_n rises.

Verification (CLK_HZ=4 unless stated)
REQ-029 Reset mid-count at 01:23 with prescaler=2, rst_n low 2 cycles -> digits 00:00, op_ack/sec_tick/expired 0, first tick 4 cycles after release.
REQ-030 MIN_MAX=2, up, run=1 from 00:00 for 180 ticks -> 02:59 after tick 179, 00:00 after tick 180; sec_tick count = 180; expired never asserted.
REQ-031 op 10 for one cycle (01:00), then down=1, run=1 -> 00:59 after the first tick; 00:00 with exactly one expired pulse after tick 60; 8 further ticks hold 00:00 with no expired.
REQ-032 MIN_MAX=59 at 59:00, op 10 held 3 cycles -> minutes 00, 01, 02 on successive cycles; op_ack high for 3 cycles, delayed one cycle.
REQ-033 Up at 00:59, op 01 coinciding with the tick -> 00:00, no minute carry, no sec_tick; next tick exactly 4 cycles later gives 00:01.
REQ-034 run=0 for 10 cycles with prescaler=1 at 00:07 -> digits and prescaler frozen; after run=1 the tick arrives 3 cycles later, giving 00:08.
